// File: rtl/mips_regfile_if.sv
`default_nettype none
// ============================================================================
// mips_regfile_if
//   Write/read bus of the MIPS25 register bank.
//   Revision: 1.0
// ============================================================================
interface mips_regfile_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) ();
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    ra_addr;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic             rd_valid;

    modport master (
        output we, waddr, wdata, re, ra_addr, rb_addr,
        input  ra_data, rb_data, rd_valid
    );

    modport slave (
        input  we, waddr, wdata, re, ra_addr, rb_addr,
        output ra_data, rb_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
// mips_regfile
//   DEPTH x WIDTH register bank, one write port, two registered read ports.
//   Revision: 1.0
// ============================================================================
module mips_regfile #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  wire logic     clkpos,
    input  wire logic     resetneg,
    mips_regfile_if.slave bus
);
    localparam logic [31:0] c_depth = DEPTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic             r_valid;
    logic             w_wr_legal;
    logic [WIDTH-1:0] w_ra_next;
    logic [WIDTH-1:0] w_rb_next;

    assign w_wr_legal = bus.we && (32'(bus.waddr) < c_depth) &&
                        !((ZERO_REG != 0) && (bus.waddr == '0));

    // Range check comes first so the array is never indexed past DEPTH-1.
    function automatic logic [WIDTH-1:0] f_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] v;
        if (32'(addr) >= c_depth)
            v = '0;
        else if ((ZERO_REG != 0) && (addr == '0))
            v = '0;
        else if ((BYPASS != 0) && w_wr_legal && (addr == bus.waddr))
            v = bus.wdata;
        else
            v = r_mem[addr];
        return v;
    endfunction

    always_comb begin
        w_ra_next = f_port(bus.ra_addr);
        w_rb_next = f_port(bus.rb_addr);
    end

    always_ff @(posedge clkpos) begin
        if (!resetneg) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_wr_legal)
                r_mem[bus.waddr] <= bus.wdata;
            if (bus.re) begin
                r_ra <= w_ra_next;
                r_rb <= w_rb_next;
            end
            r_valid <= bus.re;
        end
    end

    assign bus.ra_data  = r_ra;
    assign bus.rb_data  = r_rb;
    assign bus.rd_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_mips_regfile.sv
`default_nettype none
// ============================================================================
// tb_mips_regfile
//   Three configurations driven in lockstep against a rule-level model.
//   Revision: 1.0
// ============================================================================
module tb_mips_regfile;
    logic        clk = 1'b0;
    logic        rstn, we, re;
    logic [2:0]  waddr, ra, rb;
    logic [15:0] wdata;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // inst0: default, inst1: no zero reg / no bypass, inst2: DEPTH=6
    mips_regfile_if #(.WIDTH(16), .AW(3)) if0 ();
    mips_regfile_if #(.WIDTH(16), .AW(3)) if1 ();
    mips_regfile_if #(.WIDTH(16), .AW(3)) if2 ();

    assign if0.we = we; assign if0.waddr = waddr; assign if0.wdata = wdata;
    assign if0.re = re; assign if0.ra_addr = ra;  assign if0.rb_addr = rb;
    assign if1.we = we; assign if1.waddr = waddr; assign if1.wdata = wdata;
    assign if1.re = re; assign if1.ra_addr = ra;  assign if1.rb_addr = rb;
    assign if2.we = we; assign if2.waddr = waddr; assign if2.wdata = wdata;
    assign if2.re = re; assign if2.ra_addr = ra;  assign if2.rb_addr = rb;

    mips_regfile #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(1))
        u_dut0 (.clkpos(clk), .resetneg(rstn), .bus(if0.slave));
    mips_regfile #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(0))
        u_dut1 (.clkpos(clk), .resetneg(rstn), .bus(if1.slave));
    mips_regfile #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1), .BYPASS(1))
        u_dut2 (.clkpos(clk), .resetneg(rstn), .bus(if2.slave));

    logic [15:0] act_ra [3];
    logic [15:0] act_rb [3];
    logic        act_v  [3];
    assign act_ra[0] = if0.ra_data; assign act_rb[0] = if0.rb_data; assign act_v[0] = if0.rd_valid;
    assign act_ra[1] = if1.ra_data; assign act_rb[1] = if1.rb_data; assign act_v[1] = if1.rd_valid;
    assign act_ra[2] = if2.ra_data; assign act_rb[2] = if2.rb_data; assign act_v[2] = if2.rd_valid;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- rule-level model ----------------
    logic [15:0] m_mem [3][8];
    logic [15:0] m_ra  [3];
    logic [15:0] m_rb  [3];
    logic        m_v   [3];
    bit          armed = 1'b0;

    function automatic int  cfg_depth(int c); return (c == 2) ? 6 : 8; endfunction
    function automatic bit  cfg_zero (int c); return c != 1;           endfunction
    function automatic bit  cfg_byp  (int c); return c != 1;           endfunction

    function automatic bit m_legal(int c);
        return we && (int'(waddr) < cfg_depth(c)) && !(cfg_zero(c) && waddr == 3'd0);
    endfunction

    function automatic logic [15:0] m_read(int c, logic [2:0] a);
        if (int'(a) >= cfg_depth(c))                     return 16'h0;
        if (cfg_zero(c) && a == 3'd0)                    return 16'h0;
        if (cfg_byp(c) && m_legal(c) && a == waddr)      return wdata;
        return m_mem[c][a];
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (!rstn) begin
                for (int k = 0; k < 8; k++) m_mem[c][k] = 16'h0;
                m_ra[c] = 16'h0;
                m_rb[c] = 16'h0;
                m_v[c]  = 1'b0;
            end else begin
                if (re) begin
                    m_ra[c] = m_read(c, ra);
                    m_rb[c] = m_read(c, rb);
                end
                m_v[c] = re;
                if (m_legal(c)) m_mem[c][waddr] = wdata;
            end
        end
        if (!rstn) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("cmp%0d_ra", c), act_ra[c], m_ra[c]);
                chk($sformatf("cmp%0d_rb", c), act_rb[c], m_rb[c]);
                chk($sformatf("cmp%0d_valid", c), 16'(act_v[c]), 16'(m_v[c]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic n_rst, input logic w, input logic [2:0] wa,
                        input logic [15:0] wd, input logic r,
                        input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        rstn = n_rst; we = w; waddr = wa; wdata = wd; re = r; ra = a; rb = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; we = 1'b0; re = 1'b0;
        waddr = 3'd0; wdata = 16'h0; ra = 3'd0; rb = 3'd0;

        step(1'b0, 1'b1, 3'd3, 16'h7777, 1'b1, 3'd3, 3'd3);
        step(1'b0, 1'b1, 3'd3, 16'h7777, 1'b1, 3'd3, 3'd3);
        chk("rst_valid", 16'(if0.rd_valid), 16'h0);
        chk("rst_ra",    if0.ra_data,       16'h0);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 3'd0, 3'd0);
        step(1'b0, 1'b1, 3'd5, 16'h5555, 1'b1, 3'd5, 3'd5);
        chk("rst2_valid", 16'(if0.rd_valid), 16'h0);
        chk("rst2_ra",    if0.ra_data,       16'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(i));
            chk($sformatf("clr_ra_%0d", i), if1.ra_data, 16'h0);
            chk($sformatf("clr_rb_%0d", i), if0.rb_data, 16'h0);
        end
        chk("clr_valid", 16'(if0.rd_valid), 16'h1);

        for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 3'(i), 16'hA5A0 + 16'(i), 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(7 - i));
            chk($sformatf("sweep_ra_%0d", i), if0.ra_data, (i == 0) ? 16'h0 : 16'hA5A0 + 16'(i));
            chk($sformatf("sweep_rb_%0d", i), if0.rb_data, (i == 7) ? 16'h0 : 16'hA5A0 + 16'(7 - i));
        end

        step(1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0,    1'b1, 3'd0, 3'd0);
        chk("zero_on_ra",  if0.ra_data, 16'h0);
        chk("zero_on_rb",  if0.rb_data, 16'h0);
        chk("zero_off_ra", if1.ra_data, 16'hFFFF);
        chk("zero_off_rb", if1.rb_data, 16'hFFFF);

        step(1'b1, 1'b1, 3'd3, 16'h1111, 1'b0, 3'd0, 3'd0);
        step(1'b1, 1'b1, 3'd3, 16'h2222, 1'b1, 3'd3, 3'd3);
        chk("byp_on",  if0.ra_data, 16'h2222);
        chk("byp_off", if1.ra_data, 16'h1111);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd3);
        chk("byp_on_after",  if0.ra_data, 16'h2222);
        chk("byp_off_after", if1.ra_data, 16'h2222);

        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2);
        chk("hold_valid_pulse", 16'(if0.rd_valid), 16'h1);
        chk("hold_ra_first",    if0.ra_data,       16'hA5A2);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 3'd2, 16'h3000 + 16'(k), 1'b0, 3'd2, 3'd2);
            chk($sformatf("hold_valid_%0d", k), 16'(if0.rd_valid), 16'h0);
            chk($sformatf("hold_ra_%0d", k),    if0.ra_data,       16'hA5A2);
        end

        step(1'b1, 1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0,    1'b1, 3'd7, 3'd6);
        chk("oor_ra",   if2.ra_data, 16'h0);
        chk("oor_rb",   if2.rb_data, 16'h0);
        chk("inrange7", if0.ra_data, 16'hBEEF);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(5 - i));
        chk("oor_w3", if2.ra_data, 16'hA5A5);

        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
